// File: rtl/vga_sync_decoder.sv
// Recovers active-area pixel coordinates and a timing-lock indication from 640x480 VGA sync pulses.
// Outputs register one clock after the sampling strobe; in_pixel_stb gates every state change.
module vga_sync_decoder #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_pixel_stb,
  input  logic       in_hsync,
  input  logic       in_vsync,
  output logic [9:0] out_x,
  output logic [8:0] out_y,
  output logic       out_active,
  output logic       out_locked,
  output logic       out_frame_start,
  output logic [7:0] out_err_count
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t     state, state_nx;
  logic       hs_prev, vs_prev, h_valid, frame_bad, frame_bad_nx;
  logic [9:0] hcnt, vcnt, hs_low, hcnt_nx, vcnt_nx;
  logic       hs_fall, hs_rise, vs_fall, vs_rise;
  logic       line_err, width_err, frame_err, any_err, active_nx;

  always_comb begin
    hs_fall = hs_prev & ~in_hsync;
    hs_rise = ~hs_prev & in_hsync;
    vs_fall = vs_prev & ~in_vsync;
    vs_rise = ~vs_prev & in_vsync;

    hcnt_nx = hs_fall ? 10'd0 : ((hcnt == 10'h3ff) ? hcnt : hcnt + 10'd1);
    vcnt_nx = vcnt;
    if (vs_fall)
      vcnt_nx = 10'd0;
    else if (hs_fall && vcnt != 10'h3ff)
      vcnt_nx = vcnt + 10'd1;

    // hs_low restarts at 1 on the fall strobe, so at the rise it equals the pulse width in strobes
    line_err  = hs_fall && h_valid && (({1'b0, hcnt} + 11'd1) != 11'(H_TOTAL));
    width_err = (hs_rise && hs_low != 10'(H_SYNC)) || (vs_rise && vcnt_nx != 10'(V_SYNC));
    frame_err = vs_fall && (state != SEARCH) && (({1'b0, vcnt} + 11'd1) != 11'(V_TOTAL));
    any_err   = line_err | width_err | frame_err;

    state_nx     = state;
    frame_bad_nx = frame_bad;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nx     = MEASURE;
          frame_bad_nx = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          state_nx     = (frame_bad || any_err) ? MEASURE : LOCKED;
          frame_bad_nx = 1'b0;
        end else begin
          frame_bad_nx = frame_bad | any_err;
        end
      end
      LOCKED: begin
        if (any_err) state_nx = SEARCH;
      end
      default: state_nx = SEARCH;
    endcase

    active_nx = (state_nx == LOCKED) &&
                (hcnt_nx >= 10'(H_START)) && (hcnt_nx < 10'(H_START + 640)) &&
                (vcnt_nx >= 10'(V_START)) && (vcnt_nx < 10'(V_START + 480));
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state           <= SEARCH;
      hs_prev         <= 1'b1;
      vs_prev         <= 1'b1;
      hcnt            <= 10'd0;
      vcnt            <= 10'd0;
      hs_low          <= 10'd0;
      h_valid         <= 1'b0;
      frame_bad       <= 1'b0;
      out_x           <= 10'd0;
      out_y           <= 9'd0;
      out_active      <= 1'b0;
      out_locked      <= 1'b0;
      out_frame_start <= 1'b0;
      out_err_count   <= 8'd0;
    end else begin
      out_frame_start <= 1'b0;
      if (in_pixel_stb) begin
        hs_prev   <= in_hsync;
        vs_prev   <= in_vsync;
        hcnt      <= hcnt_nx;
        vcnt      <= vcnt_nx;
        h_valid   <= h_valid | hs_fall;
        state     <= state_nx;
        frame_bad <= frame_bad_nx;
        if (hs_fall)
          hs_low <= 10'd1;
        else if (!in_hsync && hs_low != 10'h3ff)
          hs_low <= hs_low + 10'd1;
        // several simultaneous errors still count as one event
        if (state == LOCKED && any_err && out_err_count != 8'hff)
          out_err_count <= out_err_count + 8'd1;
        out_locked      <= (state_nx == LOCKED);
        out_active      <= active_nx;
        out_x           <= active_nx ? (hcnt_nx - 10'(H_START)) : 10'd0;
        out_y           <= active_nx ? 9'(vcnt_nx - 10'(V_START)) : 9'd0;
        out_frame_start <= vs_fall && (state_nx == LOCKED);
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: three decoder instances with shrunken frame geometry so lock, boundaries,
// error paths and counter saturation all fit in a short run.
module tb_vga_sync_decoder;
  logic       clk = 1'b0;
  logic       rst, stb;
  logic       hs [3];
  logic       vs [3];
  logic [9:0] xo [3];
  logic [8:0] yo [3];
  logic       act [3];
  logic       lk [3];
  logic       fs [3];
  logic [7:0] ec [3];

  int errs = 0;
  int checks = 0;
  int lk0, fs0, fs_cnt, ul_l, ul_p;

  always #5 clk = ~clk;

  // full horizontal timing, 3-line frames
  vga_sync_decoder #(.H_TOTAL(800), .H_SYNC(96), .H_START(144), .V_TOTAL(3), .V_SYNC(1), .V_START(1)) u_h (
    .in_clock(clk), .in_reset(rst), .in_pixel_stb(stb), .in_hsync(hs[0]), .in_vsync(vs[0]),
    .out_x(xo[0]), .out_y(yo[0]), .out_active(act[0]), .out_locked(lk[0]),
    .out_frame_start(fs[0]), .out_err_count(ec[0]));

  // full vertical active area, 8-pixel lines
  vga_sync_decoder #(.H_TOTAL(8), .H_SYNC(2), .H_START(3), .V_TOTAL(516), .V_SYNC(2), .V_START(35)) u_v (
    .in_clock(clk), .in_reset(rst), .in_pixel_stb(stb), .in_hsync(hs[1]), .in_vsync(vs[1]),
    .out_x(xo[1]), .out_y(yo[1]), .out_active(act[1]), .out_locked(lk[1]),
    .out_frame_start(fs[1]), .out_err_count(ec[1]));

  // tiny frames for the saturation and reset runs
  vga_sync_decoder #(.H_TOTAL(8), .H_SYNC(2), .H_START(3), .V_TOTAL(4), .V_SYNC(1), .V_START(1)) u_s (
    .in_clock(clk), .in_reset(rst), .in_pixel_stb(stb), .in_hsync(hs[2]), .in_vsync(vs[2]),
    .out_x(xo[2]), .out_y(yo[2]), .out_active(act[2]), .out_locked(lk[2]),
    .out_frame_start(fs[2]), .out_err_count(ec[2]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input int d, input logic h, input logic v);
    hs[d] = h;
    vs[d] = v;
    stb   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One frame: line 0 starts with coincident hsync/vsync falls. Fault knobs shorten a line,
  // narrow an hsync pulse, or stall the strobe mid line 1 while the syncs toggle.
  task automatic frame(input int d, input int ht, input int hw, input int hst, input int nl,
                       input int vw, input int vst, input int short_l, input int narrow_l,
                       input int stall_p, input bit chk);
    int len, w;
    bit ea;
    lk0 = 0; fs0 = 0; fs_cnt = 0; ul_l = -1; ul_p = -1;
    for (int l = 0; l < nl; l++) begin
      len = (l == short_l) ? ht - 1 : ht;
      w   = (l == narrow_l) ? hw - 1 : hw;
      for (int p = 0; p < len; p++) begin
        pix(d, p >= w, l >= vw);
        if (l == 0 && p == 0) begin
          lk0 = int'(lk[d]);
          fs0 = int'(fs[d]);
        end
        if (fs[d]) fs_cnt++;
        if (!lk[d] && ul_l < 0) begin
          ul_l = l;
          ul_p = p;
        end
        ea = (p >= hst) && (p < hst + 640) && (l >= vst) && (l < vst + 480);
        if (chk) begin
          check("active", int'(act[d]), ea ? 1 : 0);
          check("x", int'(xo[d]), ea ? p - hst : 0);
          check("y", int'(yo[d]), ea ? l - vst : 0);
        end
        if (l == 1 && p == stall_p) begin
          stb = 1'b0;
          for (int i = 0; i < 1000; i++) begin
            hs[d] = i[0];
            vs[d] = i[1];
            @(posedge clk);
            #1;
            if (i % 100 == 99) begin
              check("stall_active", int'(act[d]), 1);
              check("stall_x", int'(xo[d]), p - hst);
              check("stall_y", int'(yo[d]), l - vst);
              check("stall_locked", int'(lk[d]), 1);
              check("stall_fs", int'(fs[d]), 0);
            end
          end
          hs[d] = 1'b1;
          vs[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic hfr(input int nl, input int short_l, input int narrow_l, input int stall_p, input bit chk);
    frame(0, 800, 96, 144, nl, 1, 1, short_l, narrow_l, stall_p, chk);
  endtask

  task automatic sfr(input int nl, input int short_l, input int vw);
    frame(2, 8, 2, 3, nl, vw, 1, short_l, -1, -1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    errs++;
    $display("FAIL watchdog: run exceeded its time budget");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stb = 1'b0;
    for (int d = 0; d < 3; d++) begin
      hs[d] = 1'b1;
      vs[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_locked", int'(lk[0]), 0);
    check("rst_err", int'(ec[0]), 0);
    check("rst_active", int'(act[0]), 0);
    check("rst_x", int'(xo[0]), 0);
    check("rst_y", int'(yo[0]), 0);
    check("rst_fs", int'(fs[0]), 0);

    // lock acquisition: MEASURE on first fall, LOCKED on the second
    hfr(3, -1, -1, -1, 1'b0);
    check("a_lk_first_fall", lk0, 0);
    check("a_lk_end", int'(lk[0]), 0);
    hfr(3, -1, -1, -1, 1'b1);
    check("b_lock_at_fall", lk0, 1);
    check("b_fs_at_fall", fs0, 1);
    check("b_fs_count", fs_cnt, 1);
    check("b_err", int'(ec[0]), 0);
    hfr(3, -1, -1, -1, 1'b1);
    check("c_fs_at_fall", fs0, 1);
    check("c_fs_count", fs_cnt, 1);

    // 799-pixel line 1: lock drops at line 2 hsync fall
    hfr(3, 1, -1, -1, 1'b0);
    check("d_lk_start", lk0, 1);
    check("d_unlock_line", ul_l, 2);
    check("d_unlock_pix", ul_p, 0);
    check("d_err", int'(ec[0]), 1);
    hfr(3, -1, -1, -1, 1'b0);
    check("e_no_lock", lk0, 0);
    hfr(3, -1, -1, -1, 1'b1);
    check("f_relock", lk0, 1);
    check("f_err", int'(ec[0]), 1);

    // 95-strobe hsync on line 2: lock drops at the rise
    hfr(3, -1, 2, -1, 1'b0);
    check("g_unlock_line", ul_l, 2);
    check("g_unlock_pix", ul_p, 95);
    check("g_err", int'(ec[0]), 2);
    hfr(3, -1, -1, -1, 1'b0);
    hfr(3, -1, -1, -1, 1'b0);
    check("i_relock", lk0, 1);

    // short frame: error at the following vsync fall
    hfr(2, -1, -1, -1, 1'b0);
    check("j_lk_start", lk0, 1);
    hfr(3, -1, -1, -1, 1'b0);
    check("k_unlock_line", ul_l, 0);
    check("k_unlock_pix", ul_p, 0);
    check("k_fs", fs0, 0);
    check("k_err", int'(ec[0]), 3);

    // relock, then strobe stall with toggling syncs mid-frame
    hfr(3, -1, -1, -1, 1'b0);
    hfr(3, -1, -1, -1, 1'b1);
    check("l2_relock", lk0, 1);
    hfr(3, -1, -1, 200, 1'b1);
    check("l3_locked", int'(lk[0]), 1);
    check("l3_err", int'(ec[0]), 3);

    // vertical boundaries: rows 514 (y=479) and 515 (inactive)
    frame(1, 8, 2, 3, 516, 2, 35, -1, -1, -1, 1'b0);
    check("v_no_lock", int'(lk[1]), 0);
    frame(1, 8, 2, 3, 516, 2, 35, -1, -1, -1, 1'b1);
    check("v_lock", lk0, 1);
    check("v_err", int'(ec[1]), 0);

    // saturation: each bad frame is preceded by a relock
    sfr(4, -1, 1);
    for (int i = 1; i <= 300; i++) begin
      sfr(4, 1, 1);
      if (i == 1) check("s_first_lk", lk0, 1);
      if (i == 100) check("s_err_100", int'(ec[2]), 100);
      if (i == 300) check("s_last_lk", lk0, 1);
      sfr(4, -1, 1);
    end
    check("s_err_sat", int'(ec[2]), 255);

    // mid-frame reset aborts lock
    sfr(4, -1, 1);
    sfr(4, -1, 1);
    check("r_lock", lk0, 1);
    sfr(2, -1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("r_lk_after_rst", int'(lk[2]), 0);
    check("r_err_after_rst", int'(ec[2]), 0);
    check("r_act_after_rst", int'(act[2]), 0);
    sfr(2, -1, 0);
    check("r_no_lock_tail", int'(lk[2]), 0);
    sfr(4, -1, 1);
    check("r_measure", lk0, 0);
    sfr(4, -1, 1);
    check("r_relock", lk0, 1);
    check("r_err_end", int'(ec[2]), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
